// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the ring-oscillator PUF comparator: default widths,
// default settle time and the controller state encoding.
// -----------------------------------------------------------------------------
package puf_pkg;

  localparam int CNT_W_DEF      = 16;  // edge counter width
  localparam int WIN_W_DEF      = 16;  // measurement window length width
  localparam int SETTLE_CYC_DEF = 8;   // oscillator warm-up cycles (1..255)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/puf_edge_sync.sv
// -----------------------------------------------------------------------------
// puf_edge_sync
// Brings an asynchronous oscillator output into the i_clk domain through a
// 2-flop synchronizer and emits a one-cycle pulse on each rising edge.
//
// Ports:
//   i_clk    - system clock
//   i_rst    - synchronous active-high reset
//   i_async  - asynchronous input (ring oscillator output)
//   o_rise   - high for one cycle per synchronized rising edge
// -----------------------------------------------------------------------------
module puf_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], i_async};
    prev_d = sync_q[1];
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (a true shift chain).
    if (i_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/puf_ro_cmp.sv
// -----------------------------------------------------------------------------
// puf_ro_cmp
// Ring-oscillator PUF comparator. On a start request it enables two external
// ring oscillators, lets them settle for SETTLE_CYC cycles, counts rising edges
// of each over a window of i_win cycles and reports which one was faster.
//
// Ports:
//   i_clk, i_rst        - system clock, synchronous active-high reset
//   i_start, i_win      - start request (IDLE only) and window length
//   i_ro_a, i_ro_b      - asynchronous oscillator outputs
//   o_en                - oscillator enable
//   o_busy              - high whenever not IDLE
//   o_valid             - one-cycle pulse when a result is published
//   o_resp              - 1 when count A > count B
//   o_cnt_a, o_cnt_b    - final edge counts (held until the next result)
// -----------------------------------------------------------------------------
module puf_ro_cmp
  import puf_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_win,
  input  logic             i_ro_a,
  input  logic             i_ro_b,
  output logic             o_en,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_resp,
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
);

  // One down-counter serves both the settle phase and the count window.
  localparam int TMR_W = (WIN_W > 8) ? WIN_W : 8;

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0]   res_a_q, res_a_d, res_b_q, res_b_d;
  logic               en_q, en_d, busy_q, busy_d, valid_q, valid_d, resp_q, resp_d;
  logic               rise_a, rise_b;
  logic               to_done;

  puf_edge_sync u_sync_a (.i_clk(i_clk), .i_rst(i_rst), .i_async(i_ro_a), .o_rise(rise_a));
  puf_edge_sync u_sync_b (.i_clk(i_clk), .i_rst(i_rst), .i_async(i_ro_b), .o_rise(rise_b));

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    win_d   = win_q;
    tmr_d   = tmr_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    res_a_d = res_a_q;
    res_b_d = res_b_q;
    en_d    = en_q;
    valid_d = 1'b0;
    resp_d  = resp_q;
    to_done = 1'b0;

    // Saturating edge counters, active only inside the window.
    if (state_q == ST_COUNT) begin
      if (rise_a && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (rise_b && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SETTLE;
          win_d   = i_win;
          tmr_d   = TMR_W'(SETTLE_CYC - 1);
          cnt_a_d = '0;
          cnt_b_d = '0;
          en_d    = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          if (win_q == '0) begin
            state_d = ST_DONE;
            to_done = 1'b1;
          end else begin
            state_d = ST_COUNT;
            tmr_d   = TMR_W'(win_q) - TMR_W'(1);
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COUNT: begin
        if (tmr_q == '0) begin
          state_d = ST_DONE;
          to_done = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Results are captured from the next-state counts so an edge seen in the
    // last window cycle is still included.
    if (to_done) begin
      en_d    = 1'b0;
      valid_d = 1'b1;
      resp_d  = (cnt_a_d > cnt_b_d);
      res_a_d = cnt_a_d;
      res_b_d = cnt_b_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      tmr_q   <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      res_a_q <= '0;
      res_b_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      tmr_q   <= tmr_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      resp_q  <= resp_d;
    end
  end

  assign o_en    = en_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_resp  = resp_q;
  assign o_cnt_a = res_a_q;
  assign o_cnt_b = res_b_q;

endmodule

// File: tb/tb_puf_ro_cmp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_puf_ro_cmp
// Scoreboard bench: each start pushes the expected result window (latency and
// count ranges); monitors pop and compare whenever a DUT raises o_valid.
// A second instance with CNT_W=4 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_puf_ro_cmp;
  import puf_pkg::*;

  localparam int S = SETTLE_CYC_DEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start_s = 1'b0;
  logic [15:0] win = '0, win_s = '0;
  logic        ro_a = 1'b0, ro_b = 1'b0;

  logic        o_en, o_busy, o_valid, o_resp;
  logic [15:0] o_cnt_a, o_cnt_b;
  logic        s_en, s_busy, s_valid, s_resp;
  logic [3:0]  s_cnt_a, s_cnt_b;

  int ro_a_half = 20;
  int ro_b_half = 30;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int exp_cyc;
    int a_lo; int a_hi;
    int b_lo; int b_hi;
    int resp;      // -1: must equal (cnt_a > cnt_b)
    int max_diff;  // -1: unchecked
  } exp_t;

  exp_t sb_q[$];
  exp_t sbs_q[$];

  puf_ro_cmp dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_win(win),
    .i_ro_a(ro_a), .i_ro_b(ro_b),
    .o_en(o_en), .o_busy(o_busy), .o_valid(o_valid), .o_resp(o_resp),
    .o_cnt_a(o_cnt_a), .o_cnt_b(o_cnt_b)
  );

  puf_ro_cmp #(.CNT_W(4)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_win(win_s),
    .i_ro_a(ro_a), .i_ro_b(ro_b),
    .o_en(s_en), .o_busy(s_busy), .o_valid(s_valid), .o_resp(s_resp),
    .o_cnt_a(s_cnt_a), .o_cnt_b(s_cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillators toggle at 1 + k*half ns, never on a clock edge.
  initial begin
    #1;
    forever begin #(ro_a_half); ro_a = ~ro_a; end
  end
  initial begin
    #1;
    forever begin #(ro_b_half); ro_b = ~ro_b; end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input int a, input int b, input int r);
    check({tag, "_latency"}, cyc, e.exp_cyc);
    check_range({tag, "_cnt_a"}, a, e.a_lo, e.a_hi);
    check_range({tag, "_cnt_b"}, b, e.b_lo, e.b_hi);
    if (e.resp >= 0) check({tag, "_resp"}, r, e.resp);
    else             check({tag, "_resp_rule"}, r, (a > b) ? 1 : 0);
    if (e.max_diff >= 0) check_range({tag, "_diff"}, (a > b) ? a - b : b - a, 0, e.max_diff);
  endtask

  // Monitors: compare at the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid) begin
      if (sb_q.size() == 0) check("main_unexpected_valid", 1, 0);
      else begin
        e = sb_q.pop_front();
        score("main", e, int'(o_cnt_a), int'(o_cnt_b), int'(o_resp));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (s_valid) begin
      if (sbs_q.size() == 0) check("sat_unexpected_valid", 1, 0);
      else begin
        e = sbs_q.pop_front();
        score("sat", e, int'(s_cnt_a), int'(s_cnt_b), int'(s_resp));
      end
    end
  end

  // Issue one comparison on the main (sel=0) or saturating (sel=1) DUT.
  // Start is high during tb cycle n; the result is due in cycle n+S+w+1.
  task automatic issue(input bit sel, input int w, input int alo, input int ahi,
                       input int blo, input int bhi, input int resp, input int md);
    exp_t e;
    @(negedge clk);
    e.exp_cyc = cyc + S + w + 1;
    e.a_lo = alo; e.a_hi = ahi; e.b_lo = blo; e.b_hi = bhi;
    e.resp = resp; e.max_diff = md;
    if (sel) begin sbs_q.push_back(e); start_s = 1'b1; win_s = 16'(w); end
    else     begin sb_q.push_back(e);  start   = 1'b1; win   = 16'(w); end
    @(negedge clk);
    start = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((sb_q.size() != 0 || sbs_q.size() != 0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain_pending", sb_q.size() + sbs_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_en", o_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_resp", o_resp, 0);
    check("rst_cnt_a", int'(o_cnt_a), 0);
    check("rst_cnt_b", int'(o_cnt_b), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A 40 ns, B 60 ns, W=120: ~30 vs ~20, A faster.
    ro_a_half = 20; ro_b_half = 30;
    issue(0, 120, 29, 31, 19, 21, 1, -1);
    wait_drain(200);

    // A 60 ns, B 40 ns, W=60: ~10 vs ~15, B faster.
    ro_a_half = 30; ro_b_half = 20;
    issue(0, 60, 9, 11, 14, 16, 0, -1);
    wait_drain(120);

    // Equal 50 ns oscillators, W=100: counts within 1, resp follows strict >.
    ro_a_half = 25; ro_b_half = 25;
    issue(0, 100, 19, 21, 19, 21, -1, 1);
    wait_drain(160);

    // W=0: result after settle only, oscillators enabled for S cycles.
    issue(0, 0, 0, 0, 0, 0, 0, -1);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("w0_en_k%0d", k), o_en, (k <= S) ? 1 : 0);
      check($sformatf("w0_busy_k%0d", k), o_busy, (k <= S + 1) ? 1 : 0);
      @(negedge clk);
    end
    wait_drain(20);

    // Restart while busy with a different window: ignored.
    ro_a_half = 20; ro_b_half = 30;
    issue(0, 40, 9, 11, 5, 8, 1, -1);
    repeat (3) @(negedge clk);
    start = 1'b1; win = 16'd10;
    @(negedge clk);
    start = 1'b0;
    wait_drain(100);
    repeat (5) @(negedge clk);
    check("hold_valid", o_valid, 0);
    check("hold_resp", o_resp, 1);

    // Saturation: CNT_W=4, A 40 ns / B 60 ns, W=200 -> both pinned at 15.
    issue(1, 200, 15, 15, 15, 15, 0, -1);
    wait_drain(260);

    // Reset in the middle of COUNT: everything cleared, no result follows.
    @(negedge clk);
    start = 1'b1; win = 16'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_abort_en", o_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_en", o_en, 0);
    check("abort_busy", o_busy, 0);
    check("abort_valid", o_valid, 0);
    check("abort_cnt_a", int'(o_cnt_a), 0);
    check("abort_cnt_b", int'(o_cnt_b), 0);
    repeat (150) @(negedge clk);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; win = 16'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("prio_busy", o_busy, 0);
    check("prio_en", o_en, 0);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/puf_ro_cmp.md
PUF_RO_CMP -- requirements
Module: puf_ro_cmp

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of each edge counter.
REQ-002 SHALL have parameter WIN_W, default 16: width of the measurement-window length input.
REQ-003 SHALL have parameter SETTLE_CYC, default 8: number of i_clk cycles the oscillators run before counting starts; legal range 1..255.
REQ-004 SHALL have port i_clk, input, 1: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port i_start, input, 1: request one comparison; sampled only in IDLE.
REQ-007 SHALL have port i_win, input, WIN_W: window length in i_clk cycles; latched when i_start is accepted.
REQ-008 SHALL have ports i_ro_a and i_ro_b, input, 1 each: asynchronous outputs of two ring oscillators.
REQ-009 SHALL have port o_en, output, 1: drives the enable of both ring oscillators.
REQ-010 SHALL have port o_busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port o_valid, output, 1: one-cycle pulse marking a finished comparison.
REQ-012 SHALL have port o_resp, output, 1: response bit, 1 when count A is greater than count B.
REQ-013 SHALL have ports o_cnt_a and o_cnt_b, output, CNT_W each: final edge counts.

Function
REQ-014 SHALL implement the FSM IDLE -> SETTLE -> COUNT -> DONE -> IDLE; all outputs are registered.
REQ-015 SHALL, in IDLE with i_start=1 at cycle t, latch i_win, clear both counters and enter SETTLE at t+1, with o_en=1 and o_busy=1 from t+1.
REQ-016 SHALL stay in SETTLE for exactly SETTLE_CYC cycles without counting, then enter COUNT at t+SETTLE_CYC+1.
REQ-017 SHALL stay in COUNT for exactly W cycles (W = latched i_win), incrementing each counter once per detected rising edge of its oscillator.
REQ-018 SHALL skip COUNT when W=0 and go from SETTLE to DONE; both counts are then 0 and o_resp=0.
REQ-019 SHALL, in DONE at cycle t+SETTLE_CYC+W+1, assert o_valid for one cycle, drive o_en=0, and update o_resp, o_cnt_a and o_cnt_b; it then returns to IDLE.
REQ-020 SHALL hold o_resp, o_cnt_a and o_cnt_b stable from DONE until the next DONE.
REQ-021 SHALL set o_resp=1 only when cnt_a > cnt_b; equal counts give o_resp=0.
REQ-022 SHALL saturate each counter at 2^CNT_W-1 with no wrap-around.
REQ-023 SHALL pass each oscillator input through a 2-flop synchronizer followed by a rising-edge detector; an edge is counted in the cycle the detector fires.
REQ-024 SHALL ignore i_start while o_busy=1; no queuing, and i_win changes have no effect.
REQ-025 SHALL require both oscillator frequencies to be below f(i_clk)/2; behaviour above that limit is undefined (undercount).

Reset
REQ-026 SHALL, when i_rst=1 at a clock edge, set state=IDLE, o_en=0, o_busy=0, o_valid=0, o_resp=0, o_cnt_a=0, o_cnt_b=0, and clear the counters and synchronizer flops.
REQ-027 SHALL let reset abort a comparison in progress: the oscillators stop the next cycle and no o_valid is issued.
REQ-028 SHALL give i_rst priority over i_start in the same cycle.

Structure
REQ-029 SHALL place the FSM state encoding and the default values of CNT_W, WIN_W and SETTLE_CYC in shared package puf_pkg.
REQ-030 SHALL use sub-module puf_edge_sync (2-flop synchronizer plus rising-edge pulse, synchronous active-high reset), instantiated once per oscillator.
REQ-031 SHALL keep the oscillator instances outside this block; o_en connects to their i_en and their o_ro outputs connect to i_ro_a and i_ro_b.

Verification
REQ-032 SHALL cover: i_clk 10 ns, i_ro_a 40 ns period, i_ro_b 60 ns period, i_win=120 -> o_valid at t+129 (SETTLE_CYC=8), o_cnt_a=30+/-1, o_cnt_b=20+/-1, o_resp=1.
REQ-033 SHALL cover: both oscillators at 50 ns, i_win=100 -> |o_cnt_a - o_cnt_b| <= 1; o_resp=0 whenever the counts are equal.
REQ-034 SHALL cover: i_win=0 -> o_valid at t+9, counts 0, o_resp=0; o_en high for cycles t+1..t+8 only.
REQ-035 SHALL cover: CNT_W=4, i_ro_a 40 ns, i_win=200 -> o_cnt_a=15 (saturated, no wrap).
REQ-036 SHALL cover: i_rst pulsed mid-COUNT -> next cycle o_en=0, o_busy=0, counts 0, and no o_valid pulse follows.
REQ-037 SHALL cover: i_start re-asserted while busy with a different i_win -> ignored; the result matches the original window.
